vga_timing_gen: RTL and testbench

//  Generates 640x480@60Hz VGA timing from the 50 MHz board clock: pixel counters, sync and blanking.

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/timing_axis.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60Hz timing constants and phase encodings.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W     = 10;

    // All three phase types share one encoding so an axis phase can be cast directly.
    typedef enum logic [1:0] {
        PH_ACT = 2'd0,
        PH_FPO = 2'd1,
        PH_SYN = 2'd2,
        PH_BPO = 2'd3
    } axis_phase_t;

    typedef enum logic [1:0] {
        H_ACT = 2'd0,
        H_FPO = 2'd1,
        H_SYN = 2'd2,
        H_BPO = 2'd3
    } h_phase_t;

    typedef enum logic [1:0] {
        V_ACT = 2'd0,
        V_FPO = 2'd1,
        V_SYN = 2'd2,
        V_BPO = 2'd3
    } v_phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the registered VGA timing outputs handed to the pixel pipeline and DAC.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic             vga_clk;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             frame_start;

    modport master (
        output vga_clk, x, y, hsync, vsync, blank_n, frame_start
    );

    modport slave (
        input vga_clk, x, y, hsync, vsync, blank_n, frame_start
    );
endinterface

// File: rtl/timing_axis.sv
// One timing axis: wrapping counter plus a four-phase FSM (active, front porch, sync, back porch).
module timing_axis
    import vga_pkg::*;
#(
    parameter int VISIBLE = 640,
    parameter int FP      = 16,
    parameter int SYNC    = 96,
    parameter int BP      = 48,
    parameter int W       = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] count,
    output logic [1:0]   phase,
    output logic         wrap
);

    localparam logic [W-1:0] ACT_END = W'(VISIBLE - 1);
    localparam logic [W-1:0] FPO_END = W'(VISIBLE + FP - 1);
    localparam logic [W-1:0] SYN_END = W'(VISIBLE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST    = W'(VISIBLE + FP + SYNC + BP - 1);

    axis_phase_t  state_reg, state_next;
    logic [W-1:0] count_reg, count_next;
    logic         at_last;

    assign at_last = (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PH_ACT;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (step) begin
            count_next = at_last ? '0 : count_reg + 1'b1;
            // Phase changes on the last count of the current phase, so the phase
            // seen alongside any count value always matches that value.
            case (state_reg)
                PH_ACT: if (count_reg == ACT_END) state_next = PH_FPO;
                PH_FPO: if (count_reg == FPO_END) state_next = PH_SYN;
                PH_SYN: if (count_reg == SYN_END) state_next = PH_BPO;
                PH_BPO: if (at_last)              state_next = PH_ACT;
                default: begin
                    state_next = PH_ACT;
                    count_next = '0;
                end
            endcase
        end
    end

    assign count = count_reg;
    assign phase = state_reg;
    assign wrap  = step & at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing: 25 MHz pixel enable from the 50 MHz clock, H/V axes, registered outputs.
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);
    import vga_pkg::*;

    logic             pix_en_reg;
    logic [CNT_W-1:0] hcount, vcount;
    logic [1:0]       h_phase_raw, v_phase_raw;
    h_phase_t         h_phase;
    v_phase_t         v_phase;
    logic             h_wrap, v_wrap, v_step;

    logic [CNT_W-1:0] x_reg, y_reg;
    logic             hsync_reg, vsync_reg, blank_n_reg;
    logic             frame_start_reg;
    logic             origin_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en_reg <= 1'b0;
        end else begin
            pix_en_reg <= ~pix_en_reg;
        end
    end

    timing_axis #(
        .VISIBLE (H_VISIBLE),
        .FP      (H_FP),
        .SYNC    (H_SYNC),
        .BP      (H_BP),
        .W       (CNT_W)
    ) u_h_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (pix_en_reg),
        .count (hcount),
        .phase (h_phase_raw),
        .wrap  (h_wrap)
    );

    assign v_step = pix_en_reg & h_wrap;

    timing_axis #(
        .VISIBLE (V_VISIBLE),
        .FP      (V_FP),
        .SYNC    (V_SYNC),
        .BP      (V_BP),
        .W       (CNT_W)
    ) u_v_axis (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (v_step),
        .count (vcount),
        .phase (v_phase_raw),
        .wrap  (v_wrap)
    );

    assign h_phase = h_phase_t'(h_phase_raw);
    assign v_phase = v_phase_t'(v_phase_raw);

    // origin_reg marks that the counters currently sit at (0,0): true out of
    // reset and after every frame wrap, so no full-width compare is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg           <= '0;
            y_reg           <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            blank_n_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            origin_reg      <= 1'b1;
        end else if (pix_en_reg) begin
            x_reg           <= hcount;
            y_reg           <= vcount;
            hsync_reg       <= ~(h_phase == H_SYN);
            vsync_reg       <= ~(v_phase == V_SYN);
            blank_n_reg     <= (h_phase == H_ACT) && (v_phase == V_ACT);
            frame_start_reg <= origin_reg;
            origin_reg      <= v_wrap;
        end else begin
            frame_start_reg <= 1'b0;
        end
    end

    assign vga.vga_clk     = pix_en_reg;
    assign vga.x           = x_reg;
    assign vga.y           = y_reg;
    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.blank_n     = blank_n_reg;
    assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for start-up and line timing, reduced-size instance for frame timing and mid-frame reset.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if vif();
    vga_timing_gen_if vif_s();

    vga_timing_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif)
    );

    // Reduced timing: H 8+2+3+3=16, V 6+2+2+3=13, so a frame is 208 pixels.
    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif_s)
    );

    typedef struct {
        logic rst_n;
        logic vga_clk;
        int   x;
        int   y;
        logic hsync;
        logic vsync;
        logic blank_n;
        logic frame_start;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad = 0;
    int   timeouts = 0;
    int   fs_glitch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge that follows an output-update edge (vga_clk low).
    task automatic next_pix();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (vif.vga_clk === 1'b0) return;
            if (vif.frame_start !== 1'b0 || vif_s.frame_start !== 1'b0) fs_glitch++;
        end
        timeouts++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seq_err, bmis, bcnt, hs_cnt, hs_first, hs_last, vs_low, fs_err;
        int ex, ey, s_err, s_blank, s_vs, s_hs, s_fs, y207, y208;

        vecs[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vga_clk", vif.vga_clk, 0);
        check("rst_x", vif.x, 0);
        check("rst_y", vif.y, 0);
        check("rst_hsync", vif.hsync, 1);
        check("rst_vsync", vif.vsync, 1);
        check("rst_blank_n", vif.blank_n, 0);
        check("rst_frame_start", vif.frame_start, 0);

        // Start-up sequence, one vector per clk edge after release
        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n;
            @(negedge clk);
            $display("startup edge %0d: vga_clk=%0d x=%0d y=%0d hs=%0d vs=%0d bn=%0d fs=%0d", i + 1,
                     vif.vga_clk, vif.x, vif.y, vif.hsync, vif.vsync, vif.blank_n, vif.frame_start);
            check($sformatf("su%0d_vga_clk", i), vif.vga_clk, vecs[i].vga_clk);
            check($sformatf("su%0d_x", i), vif.x, vecs[i].x);
            check($sformatf("su%0d_y", i), vif.y, vecs[i].y);
            check($sformatf("su%0d_hsync", i), vif.hsync, vecs[i].hsync);
            check($sformatf("su%0d_vsync", i), vif.vsync, vecs[i].vsync);
            check($sformatf("su%0d_blank_n", i), vif.blank_n, vecs[i].blank_n);
            check($sformatf("su%0d_frame_start", i), vif.frame_start, vecs[i].frame_start);
        end

        // One full line on the full-size instance
        do_reset();
        seq_err = 0; bmis = 0; bcnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; vs_low = 0; fs_err = 0;
        for (int p = 0; p <= 800; p++) begin
            next_pix();
            if (p < 800) begin
                if (vif.x !== 10'(p) || vif.y !== 10'd0) seq_err++;
                if (vif.blank_n !== (p < 640)) bmis++;
                if (vif.blank_n === 1'b1) bcnt++;
                if (vif.hsync === 1'b0) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = p;
                    hs_last = p;
                end
                if (vif.vsync !== 1'b1) vs_low++;
                if (vif.frame_start !== (p == 0)) fs_err++;
            end else begin
                check("line_wrap_x", vif.x, 0);
                check("line_wrap_y", vif.y, 1);
            end
        end
        $display("line: blank=%0d hs_low=%0d hs=[%0d..%0d]", bcnt, hs_cnt, hs_first, hs_last);
        check("line_seq_err", seq_err, 0);
        check("line_blank_mismatches", bmis, 0);
        check("line_blank_count", bcnt, 640);
        check("line_hsync_low_count", hs_cnt, 96);
        check("line_hsync_first_x", hs_first, 656);
        check("line_hsync_last_x", hs_last, 751);
        check("line_vsync_low", vs_low, 0);
        check("line_frame_start_err", fs_err, 0);

        // Two full frames plus one pixel on the reduced instance
        do_reset();
        s_err = 0; s_blank = 0; s_vs = 0; s_hs = 0; s_fs = 0; y207 = -1; y208 = -1;
        for (int p = 0; p <= 416; p++) begin
            next_pix();
            ex = p % 16;
            ey = (p / 16) % 13;
            if (vif_s.x !== 10'(ex) || vif_s.y !== 10'(ey)) s_err++;
            if (vif_s.hsync !== !(ex >= 10 && ex <= 12)) s_err++;
            if (vif_s.vsync !== !(ey >= 8 && ey <= 9)) s_err++;
            if (vif_s.blank_n !== (ex < 8 && ey < 6)) s_err++;
            if (vif_s.frame_start !== (p % 208 == 0)) s_err++;
            if (vif_s.frame_start === 1'b1) s_fs++;
            if (p < 208) begin
                if (vif_s.blank_n === 1'b1) s_blank++;
                if (vif_s.vsync === 1'b0) s_vs++;
                if (vif_s.hsync === 1'b0) s_hs++;
            end
            if (p == 207) y207 = int'(vif_s.y);
            if (p == 208) y208 = int'(vif_s.y);
        end
        $display("frame: blank=%0d vs_low=%0d hs_low=%0d fs=%0d", s_blank, s_vs, s_hs, s_fs);
        check("frame_pixel_err", s_err, 0);
        check("frame_blank_count", s_blank, 48);
        check("frame_vsync_low_count", s_vs, 32);
        check("frame_hsync_low_count", s_hs, 39);
        check("frame_start_count", s_fs, 3);
        check("frame_y_last", y207, 12);
        check("frame_y_wrap", y208, 0);

        // Mid-frame reset while both syncs are low on the reduced instance
        do_reset();
        for (int p = 0; p <= 139; p++) next_pix();
        check("pre_rst_x", vif_s.x, 11);
        check("pre_rst_y", vif_s.y, 8);
        check("pre_rst_hsync", vif_s.hsync, 0);
        check("pre_rst_vsync", vif_s.vsync, 0);
        check("pre_rst_big_x", vif.x, 139);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", vif_s.x, 0);
        check("async_rst_y", vif_s.y, 0);
        check("async_rst_hsync", vif_s.hsync, 1);
        check("async_rst_vsync", vif_s.vsync, 1);
        check("async_rst_blank_n", vif_s.blank_n, 0);
        check("async_rst_vga_clk", vif_s.vga_clk, 0);
        check("async_rst_big_x", vif.x, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        next_pix();
        $display("restart: x=%0d y=%0d bn=%0d fs=%0d", vif_s.x, vif_s.y, vif_s.blank_n, vif_s.frame_start);
        check("restart_x", vif_s.x, 0);
        check("restart_y", vif_s.y, 0);
        check("restart_blank_n", vif_s.blank_n, 1);
        check("restart_frame_start", vif_s.frame_start, 1);
        next_pix();
        check("restart_next_x", vif_s.x, 1);
        check("restart_next_fs", vif_s.frame_start, 0);

        check("pix_timeouts", timeouts, 0);
        check("frame_start_glitches", fs_glitch, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
